alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_ctrl_pkg.sv | 21 ++
 rtl/alu_seq_bus_timer.sv | 30 +++
 rtl/alu_seq_ctrl.sv | 96 +++++++++
 tb/tb_alu_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types and widths for the ALU sequencing controller.
// State encoding, opcode/flag widths and counter widths.
package alu_ctrl_pkg;

  localparam int OP_W   = 4;
  localparam int FLAG_W = 3;
  localparam int SET_W  = 4;
  localparam int TMR_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EXEC     = 3'd1,
    S_GRAB     = 3'd2,
    S_BUSREQ   = 3'd3,
    S_STORE_LO = 3'd4,
    S_STORE_HI = 3'd5,
    S_DONE     = 3'd6,
    S_ERR      = 3'd7
  } state_t;

endpackage

// File: rtl/alu_seq_bus_timer.sv
// Bus grant wait counter: cleared on start, saturating on tick.
// expired flags the last permitted wait cycle.
module alu_seq_bus_timer
  import alu_ctrl_pkg::*;
#(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic tick,
  output logic expired
);

  logic [TMR_W-1:0] cnt;

  // count ungranted wait cycles, saturating at all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (tick && (cnt != {TMR_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = ({1'b0, cnt} + 9'd1) >= 9'(LIMIT);

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer: drives an ALU op, captures flags, arbitrates
// for the data bus and strobes one or two result bytes.
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int SETTLE_CYC  = 1,
  parameter int BUS_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic              req_wide,
  output logic [OP_W-1:0]   alu_op,
  input  logic [FLAG_W-1:0] flags_in,
  output logic [FLAG_W-1:0] flags_q,
  output logic              grab,
  output logic              store_lo,
  output logic              store_hi,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              done,
  output logic              err,
  output logic              busy
);

  state_t             state;
  state_t             nxt;
  logic [SET_W-1:0]   set_cnt;
  logic [OP_W-1:0]    op_q;
  logic               wide_q;
  logic               expired;

  alu_seq_bus_timer #(
    .LIMIT(BUS_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (state == S_GRAB),
    .tick    ((state == S_BUSREQ) && !bus_gnt),
    .expired (expired)
  );

  // next-state decode
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:     if (req_valid) nxt = S_EXEC;
      S_EXEC:     if (set_cnt == 4'(SETTLE_CYC - 1)) nxt = S_GRAB;
      S_GRAB:     nxt = S_BUSREQ;
      S_BUSREQ: begin
        if (bus_gnt)      nxt = S_STORE_LO;
        else if (expired) nxt = S_ERR;
      end
      S_STORE_LO: nxt = wide_q ? S_STORE_HI : S_DONE;
      S_STORE_HI: nxt = S_DONE;
      S_DONE:     nxt = S_IDLE;
      S_ERR:      nxt = S_IDLE;
      default:    nxt = S_IDLE;
    endcase
  end

  // state, request latch, settle counter and flag capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      op_q    <= '0;
      wide_q  <= 1'b0;
      set_cnt <= '0;
      flags_q <= '0;
    end else begin
      state <= nxt;
      if ((state == S_IDLE) && req_valid) begin
        op_q   <= req_op;
        wide_q <= req_wide;
      end
      set_cnt <= (state == S_EXEC) ? set_cnt + 1'b1 : '0;
      if (state == S_GRAB) flags_q <= flags_in;
    end
  end

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign grab      = (state == S_GRAB);
  assign store_lo  = (state == S_STORE_LO);
  assign store_hi  = (state == S_STORE_HI);
  assign done      = (state == S_DONE);
  assign err       = (state == S_ERR);
  assign bus_req   = (state == S_BUSREQ) ||
                     (state == S_STORE_LO) ||
                     (state == S_STORE_HI);
  assign alu_op    = ((state == S_EXEC) || (state == S_GRAB))
                     ? op_q : '0;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: per-cycle input tables,
// a timeline model of each op, and per-cycle comparison.
module tb_alu_seq_ctrl;

  localparam int N  = 120;
  localparam int S  = 1;
  localparam int TO = 15;

  localparam int K_IDLE = 0;
  localparam int K_EXEC = 1;
  localparam int K_GRAB = 2;
  localparam int K_BR   = 3;
  localparam int K_LO   = 4;
  localparam int K_HI   = 5;
  localparam int K_DONE = 6;
  localparam int K_ERR  = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_op;
  logic       req_wide;
  logic [3:0] alu_op;
  logic [2:0] flags_in;
  logic [2:0] flags_q;
  logic       grab, store_lo, store_hi;
  logic       bus_req, bus_gnt;
  logic       done, err, busy;

  logic       rv_a [N];
  logic       gnt_a[N];
  logic       rst_a[N];
  logic       wd_a [N];
  logic [3:0] op_a [N];
  logic [2:0] fl_a [N];

  int         kind [N];
  logic [3:0] eop  [N];
  logic [2:0] efl  [N];

  int cyc = 0;
  int nvec = 0;
  int nbad = 0;
  int br_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(
    .SETTLE_CYC (S),
    .BUS_TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_wide (req_wide),
    .alu_op   (alu_op),
    .flags_in (flags_in),
    .flags_q  (flags_q),
    .grab     (grab),
    .store_lo (store_lo),
    .store_hi (store_hi),
    .bus_req  (bus_req),
    .bus_gnt  (bus_gnt),
    .done     (done),
    .err      (err),
    .busy     (busy)
  );

  task automatic chk(input string n, input int got, input int want);
    nvec++;
    if (got != want) begin
      nbad++;
      $display("FAIL cyc=%0d %s got=%0h want=%0h", cyc, n, got, want);
    end
  endtask

  task automatic place(inout int t, input int k,
                       input logic [3:0] o, inout logic ab);
    if (t < N) begin
      kind[t] = k;
      eop[t]  = o;
      ab      = rst_a[t];
    end else begin
      ab = 1'b1;
    end
    t++;
  endtask

  // lay out each accepted op as a sequence of phase cycles
  task automatic build_model();
    int c, t, j;
    logic [3:0] o;
    logic w, ab, g;
    logic [2:0] f;
    for (int i = 0; i < N; i++) begin
      kind[i] = K_IDLE;
      eop[i]  = '0;
    end
    c = 0;
    while (c < N) begin
      if (rst_a[c] || !rv_a[c]) begin
        c++;
        continue;
      end
      o = op_a[c];
      w = wd_a[c];
      t = c + 1;
      ab = 1'b0;
      for (int s = 0; s < S; s++)
        if (!ab) place(t, K_EXEC, o, ab);
      if (!ab) place(t, K_GRAB, o, ab);
      j = 0;
      g = 1'b0;
      while (!ab && !g && j < TO) begin
        g = (t < N) ? gnt_a[t] : 1'b0;
        j++;
        place(t, K_BR, 4'h0, ab);
      end
      if (!ab) begin
        if (g) begin
          place(t, K_LO, 4'h0, ab);
          if (w && !ab) place(t, K_HI, 4'h0, ab);
          if (!ab) place(t, K_DONE, 4'h0, ab);
        end else begin
          place(t, K_ERR, 4'h0, ab);
        end
      end
      c = t;
    end
    f = '0;
    for (int i = 0; i < N; i++) begin
      efl[i] = f;
      if (rst_a[i]) f = '0;
      else if (kind[i] == K_GRAB) f = fl_a[i];
    end
  endtask

  task automatic apply(input int c);
    reset     = rst_a[c];
    req_valid = rv_a[c];
    bus_gnt   = gnt_a[c];
    req_op    = op_a[c];
    req_wide  = wd_a[c];
    flags_in  = fl_a[c];
  endtask

  // per-cycle comparison plus hand-computed anchors
  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk("req_ready", int'(req_ready), int'(kind[cyc] == K_IDLE));
      chk("busy", int'(busy), int'(kind[cyc] != K_IDLE));
      chk("grab", int'(grab), int'(kind[cyc] == K_GRAB));
      chk("store_lo", int'(store_lo), int'(kind[cyc] == K_LO));
      chk("store_hi", int'(store_hi), int'(kind[cyc] == K_HI));
      chk("done", int'(done), int'(kind[cyc] == K_DONE));
      chk("err", int'(err), int'(kind[cyc] == K_ERR));
      chk("bus_req", int'(bus_req),
          int'(kind[cyc] == K_BR || kind[cyc] == K_LO ||
               kind[cyc] == K_HI));
      chk("alu_op", int'(alu_op), int'(eop[cyc]));
      chk("flags_q", int'(flags_q), int'(efl[cyc]));
      if (cyc >= 22 && cyc <= 44 && bus_req) br_cnt++;
      if (err) err_cnt++;
      case (cyc)
        2:   begin
               chk("rst_ready", int'(req_ready), 1);
               chk("rst_flags", int'(flags_q), 0);
             end
        4:   chk("a_op", int'(alu_op), 3);
        5:   chk("a_grab", int'(grab), 1);
        7:   chk("a_lo", int'(store_lo), 1);
        8:   chk("a_done", int'(done), 1);
        9:   chk("a_flags", int'(flags_q), 5);
        16:  chk("b_lo", int'(store_lo), 1);
        17:  chk("b_hi", int'(store_hi), 1);
        18:  chk("b_done", int'(done), 1);
        39:  chk("c_busreq", int'(bus_req), 1);
        40:  chk("c_err", int'(err), 1);
        41:  chk("c_idle", int'(busy), 0);
        51:  chk("d_busreq", int'(bus_req), 1);
        52:  chk("d_lo", int'(store_lo), 1);
        65:  chk("e_done", int'(done), 1);
        66:  chk("e_ready", int'(req_ready), 1);
        68:  chk("e_grab2", int'(grab), 1);
        89:  chk("f_lo", int'(store_lo), 1);
        90:  begin
               chk("f_busy", int'(busy), 0);
               chk("f_hi", int'(store_hi), 0);
             end
        96:  chk("g_idle", int'(busy), 0);
        105: chk("h_done", int'(done), 1);
        default: ;
      endcase
    end
  end

  initial begin
    for (int c = 0; c < N; c++) begin
      rv_a[c]  = 1'b0;
      gnt_a[c] = 1'b1;
      rst_a[c] = 1'b0;
      wd_a[c]  = 1'b0;
      op_a[c]  = 4'h0;
      fl_a[c]  = 3'(c * 3 + 1);
    end
    rst_a[0] = 1'b1;
    rst_a[1] = 1'b1;
    rv_a[3] = 1'b1;  op_a[3] = 4'h3;  fl_a[5] = 3'b101;
    rv_a[12] = 1'b1; op_a[12] = 4'h9; wd_a[12] = 1'b1;
    rv_a[22] = 1'b1; op_a[22] = 4'h6;
    for (int c = 22; c <= 50; c++) gnt_a[c] = 1'b0;
    rv_a[45] = 1'b1; op_a[45] = 4'hC;
    for (int c = 60; c <= 75; c++) begin
      rv_a[c] = 1'b1;
      op_a[c] = 4'h5;
    end
    rv_a[85] = 1'b1; op_a[85] = 4'h7; wd_a[85] = 1'b1;
    rst_a[89] = 1'b1;
    rv_a[95] = 1'b1; op_a[95] = 4'hE; rst_a[95] = 1'b1;
    rv_a[100] = 1'b1; op_a[100] = 4'hA;
    build_model();
    chk("m_kind_a_done", kind[8], K_DONE);
    chk("m_kind_c_err", kind[40], K_ERR);
    chk("m_kind_f_idle", kind[90], K_IDLE);
    apply(0);
    for (int c = 1; c < N; c++) begin
      @(posedge clk);
      cyc = c;
      #1 apply(c);
    end
    @(posedge clk);
    #2;
    chk("c_busreq_cycles", br_cnt, 15);
    chk("err_pulses", err_cnt, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
